seg_scan_ctrl: RTL and testbench

Parametrised seven-segment display controller for the CPU24 FPGA top level. It selects one of NUM_CH 32-bit debug channels (a0, period count, jump counts, memory word, …) and holds the displayed value in a register. The value can be frozen on request. The block time-multiplexes the value across an active-low DIGITS-digit hex display, which removes the separate scan/decode logic from the board wrapper. The channel is chosen by a step pulse (button) or a direct load.

---
 rtl/seg_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Seven-segment debug display controller: picks one of NUM_CH channel words,
// optionally freezes it, and scans it across an active-low multi-digit hex display.
module seg_scan_ctrl #(
    parameter int NUM_CH   = 5,
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000,
    parameter int BLANK_LZ = 0,
    localparam int DW      = 4 * DIGITS,
    localparam int CW      = $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH*DW-1:0] ch_data,
    input  logic                 mode_step,
    input  logic                 mode_set_en,
    input  logic [CW-1:0]        mode_set_val,
    input  logic                 freeze,
    output logic [CW-1:0]        mode,
    output logic [DW-1:0]        seg_num,
    output logic [DIGITS-1:0]    an,
    output logic [7:0]           seg
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SW = $clog2(SCAN_DIV);

    localparam logic [CW:0]   NCH_W    = (CW+1)'(NUM_CH);
    localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CH - 1);
    localparam logic [SW-1:0] LAST_CNT = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    logic [CW-1:0]     r_mode;
    logic [DW-1:0]     r_seg_num;
    logic [SW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic [DIGITS-1:0] r_an;
    logic [7:0]        r_seg;

    logic [DW-1:0]     w_ch [NUM_CH];
    logic [DW-1:0]     w_shifted;
    logic [3:0]        w_nib;
    logic              w_upper_zero;
    logic [6:0]        w_seg_lo;

    // Active-low g..a pattern for one hex nibble
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h40;  4'h1: p = 7'h79;  4'h2: p = 7'h24;  4'h3: p = 7'h30;
            4'h4: p = 7'h19;  4'h5: p = 7'h12;  4'h6: p = 7'h02;  4'h7: p = 7'h78;
            4'h8: p = 7'h00;  4'h9: p = 7'h10;  4'hA: p = 7'h08;  4'hB: p = 7'h03;
            4'hC: p = 7'h46;  4'hD: p = 7'h21;  4'hE: p = 7'h06;  4'hF: p = 7'h0E;
            default: p = 7'h7F;
        endcase
        return p;
    endfunction

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign w_ch[k] = ch_data[k*DW +: DW];
    end

    // Shifting the whole value down gives both the current nibble and the
    // "this and all higher nibbles are zero" test used for blanking.
    assign w_shifted    = r_seg_num >> {r_idx, 2'b00};
    assign w_nib        = w_shifted[3:0];
    assign w_upper_zero = (w_shifted == '0);

    // Channel register: an out-of-range load swallows the step as well
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= '0;
        end else if (mode_set_en) begin
            if ({1'b0, mode_set_val} < NCH_W) begin
                r_mode <= mode_set_val;
            end
        end else if (mode_step) begin
            r_mode <= (r_mode == LAST_CH) ? '0 : r_mode + CW'(1);
        end
    end

    // Displayed value capture, held while frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_num <= '0;
        end else if (!freeze) begin
            r_seg_num <= w_ch[r_mode];
        end
    end

    // Digit scan timer and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == LAST_CNT) begin
            r_cnt <= '0;
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
        end else begin
            r_cnt <= r_cnt + SW'(1);
        end
    end

    // Segment pattern for the digit currently selected, with optional blanking
    always_comb begin
        w_seg_lo = hex7(w_nib);
        if ((BLANK_LZ != 0) && (r_idx != '0) && w_upper_zero) begin
            w_seg_lo = 7'h7F;
        end else begin
            w_seg_lo = hex7(w_nib);
        end
    end

    // Registered display drive; dp on digit 0 flags a frozen value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= '1;
            r_seg <= 8'hFF;
        end else begin
            r_an  <= ~(DIGITS'(1) << r_idx);
            r_seg <= {~((r_idx == '0) && freeze), w_seg_lo};
        end
    end

    assign mode    = r_mode;
    assign seg_num = r_seg_num;
    assign an      = r_an;
    assign seg     = r_seg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed steps plus random traffic,
// compared every cycle against a cycle-count based reference model.
module tb_seg_scan_ctrl;

    localparam int NC = 5;
    localparam int DG = 8;
    localparam int SD = 4;
    localparam int DW = 4 * DG;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NC*DW-1:0] ch_data = '0;
    logic            mode_step = 1'b0;
    logic            mode_set_en = 1'b0;
    logic [2:0]      mode_set_val = 3'd0;
    logic            freeze = 1'b0;
    logic [2:0]      mode, mode_b;
    logic [DW-1:0]   seg_num, seg_num_b;
    logic [DG-1:0]   an, an_b;
    logic [7:0]      seg, seg_b;

    int total = 0;
    int bad   = 0;

    logic [2:0]  m_mode = 3'd0;
    logic [31:0] m_val  = 32'd0;
    int          m_k    = 0;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    seg_scan_ctrl #(.NUM_CH(NC), .DIGITS(DG), .SCAN_DIV(SD), .BLANK_LZ(0)) dut (
        .clk(clk), .rst(rst), .ch_data(ch_data), .mode_step(mode_step),
        .mode_set_en(mode_set_en), .mode_set_val(mode_set_val), .freeze(freeze),
        .mode(mode), .seg_num(seg_num), .an(an), .seg(seg));

    seg_scan_ctrl #(.NUM_CH(NC), .DIGITS(DG), .SCAN_DIV(SD), .BLANK_LZ(1)) dut_b (
        .clk(clk), .rst(rst), .ch_data(ch_data), .mode_step(mode_step),
        .mode_set_en(mode_set_en), .mode_set_val(mode_set_val), .freeze(freeze),
        .mode(mode_b), .seg_num(seg_num_b), .an(an_b), .seg(seg_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_ch(input int c, input logic [31:0] v);
        ch_data[c*DW +: DW] = v;
    endtask

    // One clock: predict from the spec rules, advance, compare all outputs.
    task automatic tick();
        int          idx;
        logic [7:0]  e_an, e_seg, e_segb;
        logic [3:0]  nib;
        logic        lz;
        idx = (m_k / SD) % DG;
        if (rst) begin
            e_an = 8'hFF; e_seg = 8'hFF; e_segb = 8'hFF;
            m_mode = 3'd0; m_val = 32'd0; m_k = 0;
        end else begin
            e_an  = ~(8'd1 << idx);
            nib   = 4'((m_val >> (4 * idx)) & 32'hF);
            lz    = (idx > 0) && ((m_val >> (4 * idx)) == 32'd0);
            e_seg = {~((idx == 0) && freeze), hex_tab[nib]};
            e_segb = lz ? {e_seg[7], 7'h7F} : e_seg;
            if (!freeze) m_val = ch_data[int'(m_mode)*DW +: DW];
            if (mode_set_en) begin
                if (int'(mode_set_val) < NC) m_mode = mode_set_val;
            end else if (mode_step) begin
                m_mode = (int'(m_mode) + 1 == NC) ? 3'd0 : m_mode + 3'd1;
            end
            m_k++;
        end
        @(posedge clk);
        #1;
        chk("mode",    32'(mode),    32'(m_mode));
        chk("seg_num", seg_num,      m_val);
        chk("an",      32'(an),      32'(e_an));
        chk("seg",     32'(seg),     32'(e_seg));
        chk("an_b",    32'(an_b),    32'(e_an));
        chk("seg_b",   32'(seg_b),   32'(e_segb));
    endtask

    initial begin
        int         lit [DG];
        logic [7:0] rec [DG];
        logic [7:0] exp_blank [DG];
        int         dp_cnt;
        int         guard;

        // Reset
        rst = 1'b1;
        for (int c = 0; c < NC; c++) set_ch(c, $urandom());
        tick();
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_an",   32'(an),   32'hFF);
        chk("rst_seg",  32'(seg),  32'hFF);

        // Frame scan with channel 0 = 0x1234ABCD
        set_ch(0, 32'h1234ABCD);
        rst = 1'b0;
        for (int d = 0; d < DG; d++) lit[d] = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            for (int d = 0; d < DG; d++) if (an[d] == 1'b0) lit[d]++;
            if (i == 0)  chk("first_seg", 32'(seg), 32'hC0);
            if (i == 3)  chk("dig0_d",    32'(seg), 32'hA1);
            if (i == 31) chk("dig7_1",    32'(seg), 32'hF9);
        end
        for (int d = 0; d < DG; d++) chk("lit_cycles", 32'(lit[d]), 32'd4);

        // Five step pulses: 1,2,3,4,0
        for (int i = 0; i < 5; i++) begin
            for (int c = 0; c < NC; c++) set_ch(c, $urandom());
            mode_step = 1'b1;
            tick();
            mode_step = 1'b0;
            chk("step_seq", 32'(mode), 32'((i + 1) % NC));
            tick();
        end

        // Set has priority over step; out-of-range set blocks the step
        mode_step = 1'b1; mode_set_en = 1'b1; mode_set_val = 3'd3;
        tick();
        chk("set_prio", 32'(mode), 32'd3);
        mode_set_val = 3'd7;
        tick();
        chk("set_oor", 32'(mode), 32'd3);
        mode_step = 1'b0; mode_set_en = 1'b0;

        // Freeze holds the value and lights dp on digit 0
        set_ch(3, 32'h5);
        tick(); tick();
        chk("pre_freeze", seg_num, 32'h5);
        freeze = 1'b1;
        set_ch(3, 32'h9);
        dp_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (an == 8'hFE && seg[7] == 1'b0) dp_cnt++;
        end
        chk("frozen_val", seg_num, 32'h5);
        chk("dp_count",   32'(dp_cnt), 32'd4);
        freeze = 1'b0;
        tick();
        chk("unfreeze", seg_num, 32'h9);

        // Leading-zero blanking: 0x00000A00 then 0
        for (int v = 0; v < 2; v++) begin
            set_ch(3, (v == 0) ? 32'h00000A00 : 32'h0);
            for (int d = 0; d < DG; d++) exp_blank[d] = 8'hFF;
            exp_blank[0] = 8'hC0;
            if (v == 0) begin
                exp_blank[1] = 8'hC0;
                exp_blank[2] = 8'h88;
            end
            tick(); tick();
            for (int d = 0; d < DG; d++) rec[d] = 8'h00;
            for (int i = 0; i < 32; i++) begin
                tick();
                for (int d = 0; d < DG; d++) if (an_b == ~(8'd1 << d)) rec[d] = seg_b;
            end
            for (int d = 0; d < DG; d++) chk("blank_digit", 32'(rec[d]), 32'(exp_blank[d]));
        end

        // Random traffic with occasional reset
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < NC; c++) set_ch(c, $urandom());
            mode_step    = ($urandom_range(0, 3) == 0);
            mode_set_en  = ($urandom_range(0, 7) == 0);
            mode_set_val = 3'($urandom_range(0, 7));
            freeze       = ($urandom_range(0, 4) == 0);
            rst          = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst = 1'b0; mode_step = 1'b0; freeze = 1'b0;

        // Reset mid-frame with idx=5 and mode=2
        mode_set_en = 1'b1; mode_set_val = 3'd2;
        tick();
        mode_set_en = 1'b0;
        guard = 0;
        while (((m_k / SD) % DG) != 5 && guard < 64) begin
            tick();
            guard++;
        end
        chk("reach_idx5", 32'((m_k / SD) % DG), 32'd5);
        chk("pre_rst_mode", 32'(mode), 32'd2);
        rst = 1'b1; mode_step = 1'b1; freeze = 1'b1;
        tick();
        chk("midrst_mode", 32'(mode),    32'd0);
        chk("midrst_num",  seg_num,      32'd0);
        chk("midrst_an",   32'(an),      32'hFF);
        chk("midrst_seg",  32'(seg),     32'hFF);
        rst = 1'b0; mode_step = 1'b0; freeze = 1'b0;
        tick();
        chk("post_rst_an", 32'(an), 32'hFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
